xcore_redirect_ctrl: RTL and testbench

- Fetch-redirect scheduler sitting between the static branch predictor, the IF stage and the EX-stage branch resolver.
- Tracks every in-flight control-flow prediction in a small FIFO and checks each one against its EX resolution.
- On a mispredict, issues a single redirect plus pipeline flush. Otherwise forwards predicted-taken redirects to fetch.
- Freezes IF while a JALR is unresolved.

---
 rtl/xcore_rdc_pkg.sv | 27 ++
 rtl/xcore_rdc_fifo.sv | 59 +++++
 rtl/xcore_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_xcore_redirect_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/xcore_rdc_pkg.sv
// xcore_rdc_pkg: shared FSM encoding, prediction-entry layout and opcode constants
// for the fetch-redirect controller. Rev 1.0
`default_nettype none

package xcore_rdc_pkg;

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_JALR_WAIT = 2'b01;
  localparam logic [1:0] ST_FLUSH     = 2'b10;

  // Entry layout: {is_jalr, pred_taken, pred_tgt[XLEN-1:0]}; control bits sit above the target
  localparam int ENT_CTRL_W    = 2;
  localparam int ENT_TGT_LSB   = 0;
  localparam int ENT_TAKEN_OFS = 0;
  localparam int ENT_JALR_OFS  = 1;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic int ent_width(input int xlen);
    return xlen + ENT_CTRL_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xcore_rdc_fifo.sv
// xcore_rdc_fifo: synchronous FIFO with push/pop/clear, full/empty flags and head view;
// clear has priority over push and pop. Rev 1.0
`default_nettype none

module xcore_rdc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/xcore_redirect_ctrl.sv
// xcore_redirect_ctrl: fetch-redirect scheduler checking in-flight predictions against EX;
// optional perf counters under XCORE_RDC_PERF_EN. Rev 1.0
`default_nettype none

module xcore_redirect_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            rdc_clk,
  input  logic            rdc_rst,
  input  logic            if_valid,
  input  logic            if_is_jalr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            bpu_jump_valid,
  input  logic [XLEN-1:0] bpu_instr_adr,
  input  logic            ex_resolve_valid,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            fetch_redirect_valid,
  output logic [XLEN-1:0] fetch_redirect_pc,
  output logic            fetch_freeze,
  output logic            pipe_flush,
  output logic            rdc_stall
`ifdef XCORE_RDC_PERF_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mis_cnt
`endif
);

  import xcore_rdc_pkg::*;

  localparam int ENT_W = ent_width(XLEN);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] redir_pc;
  logic            empty;
  logic            full;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] push_ent;
  logic            head_jalr;
  logic            head_taken;
  logic [XLEN-1:0] head_tgt;
  logic            pop;
  logic            push;
  logic            mis;
  logic            jalr_done;
  logic            pred_taken;
  logic [XLEN-1:0] pred_tgt;
  logic [XLEN-1:0] fix_pc;

  assign head_jalr  = head[XLEN+ENT_JALR_OFS];
  assign head_taken = head[XLEN+ENT_TAKEN_OFS];
  assign head_tgt   = head[ENT_TGT_LSB +: XLEN];

  assign pop  = ex_resolve_valid & ~empty & (state != ST_FLUSH);
  assign mis  = pop & ~head_jalr &
                ((ex_taken != head_taken) | (ex_taken & (ex_target != head_tgt)));
  assign push = if_valid & ~full & (state == ST_RUN) & ~mis;

  assign jalr_done = pop & head_jalr & (state == ST_JALR_WAIT);
  assign fix_pc    = ex_taken ? ex_target : head_tgt;

  assign pred_taken = bpu_jump_valid & ~if_is_jalr;
  assign pred_tgt   = pred_taken ? bpu_instr_adr : (if_pc + XLEN'(4));
  assign push_ent   = {if_is_jalr, pred_taken, pred_tgt};

  xcore_rdc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (rdc_clk),
    .rst   (rdc_rst),
    .push  (push),
    .pop   (pop),
    .clear (state == ST_FLUSH),
    .din   (push_ent),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (mis)                      state_nxt = ST_FLUSH;
        else if (push && if_is_jalr)  state_nxt = ST_JALR_WAIT;
      end
      ST_JALR_WAIT: begin
        if (jalr_done)                state_nxt = ST_RUN;
        else if (mis)                 state_nxt = ST_FLUSH;
      end
      ST_FLUSH:                       state_nxt = ST_RUN;
      default:                        state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge rdc_clk) begin
    if (rdc_rst) begin
      state    <= ST_RUN;
      redir_pc <= '0;
    end else begin
      state <= state_nxt;
      if (mis) redir_pc <= fix_pc;
    end
  end

  // Flush redirect cannot collide with a predicted one: push is blocked outside RUN
  always_comb begin
    fetch_redirect_valid = 1'b0;
    fetch_redirect_pc    = '0;
    if (state == ST_FLUSH) begin
      fetch_redirect_valid = 1'b1;
      fetch_redirect_pc    = redir_pc;
    end else if (jalr_done) begin
      fetch_redirect_valid = 1'b1;
      fetch_redirect_pc    = ex_target;
    end else if (push && pred_taken) begin
      fetch_redirect_valid = 1'b1;
      fetch_redirect_pc    = bpu_instr_adr;
    end
  end

  assign pipe_flush   = (state == ST_FLUSH);
  assign fetch_freeze = (state == ST_JALR_WAIT) | (push & if_is_jalr);
  assign rdc_stall    = full;

`ifdef XCORE_RDC_PERF_EN
  always_ff @(posedge rdc_clk) begin
    if (rdc_rst) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else begin
      if (pop) perf_br_cnt  <= perf_br_cnt + 32'd1;
      if (mis) perf_mis_cnt <= perf_mis_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xcore_redirect_ctrl.sv
// tb_xcore_redirect_ctrl: directed scoreboard bench for xcore_redirect_ctrl. Rev 1.0
`default_nettype none

module tb_xcore_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_is_jalr, bpu_jump_valid;
  logic [31:0] if_pc, bpu_instr_adr;
  logic        ex_resolve_valid, ex_taken;
  logic [31:0] ex_target;
  logic        fetch_redirect_valid, fetch_freeze, pipe_flush, rdc_stall;
  logic [31:0] fetch_redirect_pc;
`ifdef XCORE_RDC_PERF_EN
  logic [31:0] perf_br_cnt, perf_mis_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xcore_redirect_ctrl #(.DEPTH(4), .XLEN(32)) dut (
    .rdc_clk              (clk),
    .rdc_rst              (rst),
    .if_valid             (if_valid),
    .if_is_jalr           (if_is_jalr),
    .if_pc                (if_pc),
    .bpu_jump_valid       (bpu_jump_valid),
    .bpu_instr_adr        (bpu_instr_adr),
    .ex_resolve_valid     (ex_resolve_valid),
    .ex_taken             (ex_taken),
    .ex_target            (ex_target),
    .fetch_redirect_valid (fetch_redirect_valid),
    .fetch_redirect_pc    (fetch_redirect_pc),
    .fetch_freeze         (fetch_freeze),
    .pipe_flush           (pipe_flush),
    .rdc_stall            (rdc_stall)
`ifdef XCORE_RDC_PERF_EN
    ,
    .perf_br_cnt          (perf_br_cnt),
    .perf_mis_cnt         (perf_mis_cnt)
`endif
  );

  typedef struct {
    logic        rst, ifv, jalr, bj, rv, rt;
    logic [31:0] pc, badr, rtgt;
  } in_t;

  typedef struct {
    string       tag;
    bit          chk;
    logic        rv, fl, fz, st;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];

  function automatic in_t idle();
    in_t s;
    s.rst = 0; s.ifv = 0; s.jalr = 0; s.bj = 0; s.rv = 0; s.rt = 0;
    s.pc = 0; s.badr = 0; s.rtgt = 0;
    return s;
  endfunction

  function automatic in_t rst_in();
    in_t s = idle();
    s.rst = 1;
    return s;
  endfunction

  function automatic in_t br(logic [31:0] pc, logic bj, logic [31:0] adr);
    in_t s = idle();
    s.ifv = 1; s.pc = pc; s.bj = bj; s.badr = adr;
    return s;
  endfunction

  function automatic in_t jalr(logic [31:0] pc);
    in_t s = br(pc, 1'b1, 32'h999);
    s.jalr = 1;
    return s;
  endfunction

  function automatic in_t res(logic t, logic [31:0] tgt);
    in_t s = idle();
    s.rv = 1; s.rt = t; s.rtgt = tgt;
    return s;
  endfunction

  function automatic exp_t E(string tag, logic rv, logic [31:0] pc, logic fl, logic fz, logic st);
    exp_t e;
    e.tag = tag; e.chk = 1; e.rv = rv; e.rpc = pc; e.fl = fl; e.fz = fz; e.st = st;
    return e;
  endfunction

  function automatic exp_t NOCHK();
    exp_t e = E("none", 0, 0, 0, 0, 0);
    e.chk = 0;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    exp_t e = sb.pop_front();
    if (e.chk) begin
      cmp({e.tag, ".redirect_valid"}, 32'(fetch_redirect_valid), 32'(e.rv));
      cmp({e.tag, ".redirect_pc"},    fetch_redirect_pc,          e.rpc);
      cmp({e.tag, ".pipe_flush"},     32'(pipe_flush),           32'(e.fl));
      cmp({e.tag, ".fetch_freeze"},   32'(fetch_freeze),         32'(e.fz));
      cmp({e.tag, ".rdc_stall"},      32'(rdc_stall),            32'(e.st));
    end
  endtask

  task automatic step(input in_t s, input exp_t e);
    @(posedge clk); #1;
    rst = s.rst; if_valid = s.ifv; if_is_jalr = s.jalr; if_pc = s.pc;
    bpu_jump_valid = s.bj; bpu_instr_adr = s.badr;
    ex_resolve_valid = s.rv; ex_taken = s.rt; ex_target = s.rtgt;
    sb.push_back(e);
    @(negedge clk);
    check_head();
  endtask

  task automatic check_perf(input string tag, input logic [31:0] br_c, input logic [31:0] mis_c);
`ifdef XCORE_RDC_PERF_EN
    cmp({tag, ".perf_br_cnt"},  perf_br_cnt,  br_c);
    cmp({tag, ".perf_mis_cnt"}, perf_mis_cnt, mis_c);
`else
    if (tag.len() == 0) $display("perf %0d %0d", br_c, mis_c);
`endif
  endtask

  initial begin
    rst = 1; if_valid = 0; if_is_jalr = 0; if_pc = 0; bpu_jump_valid = 0; bpu_instr_adr = 0;
    ex_resolve_valid = 0; ex_taken = 0; ex_target = 0;
    step(rst_in(), NOCHK());
    step(rst_in(), NOCHK());
    step(idle(), E("reset", 0, 0, 0, 0, 0));
    check_perf("reset", 0, 0);

    // Correctly predicted backward branch
    step(br(32'h100, 1, 32'hF0), E("bt_if",  1, 32'hF0, 0, 0, 0));
    step(res(1, 32'hF0),         E("bt_res", 0, 0, 0, 0, 0));
    step(idle(),                 E("bt_post", 0, 0, 0, 0, 0));
    check_perf("bt", 1, 0);

    // Forward branch predicted not taken, actually taken
    step(br(32'h200, 0, 0),      E("fw_if",   0, 0, 0, 0, 0));
    step(res(1, 32'h240),        E("fw_res",  0, 0, 0, 0, 0));
    step(idle(),                 E("fw_flush", 1, 32'h240, 1, 0, 0));
    step(idle(),                 E("fw_post", 0, 0, 0, 0, 0));
    step(res(1, 32'h999),        E("fw_ignres", 0, 0, 0, 0, 0));
    step(idle(),                 E("fw_empty", 0, 0, 0, 0, 0));
    check_perf("fw", 2, 1);

    // JALR freeze and resolution
    step(jalr(32'h300),          E("jr_if",   0, 0, 0, 1, 0));
    step(br(32'h304, 1, 32'h50), E("jr_wait", 0, 0, 0, 1, 0));
    step(res(1, 32'h1000),       E("jr_res",  1, 32'h1000, 0, 1, 0));
    step(idle(),                 E("jr_post", 0, 0, 0, 0, 0));
    step(res(1, 32'h50),         E("jr_ignres", 0, 0, 0, 0, 0));
    step(idle(),                 E("jr_empty", 0, 0, 0, 0, 0));

    // Fill to DEPTH, fifth instruction must be held off
    step(br(32'h400, 0, 0),      E("full_p0", 0, 0, 0, 0, 0));
    step(br(32'h404, 0, 0),      E("full_p1", 0, 0, 0, 0, 0));
    step(br(32'h408, 0, 0),      E("full_p2", 0, 0, 0, 0, 0));
    step(br(32'h40C, 0, 0),      E("full_p3", 0, 0, 0, 0, 0));
    step(br(32'h410, 1, 32'h500), E("full_p4", 0, 0, 0, 0, 1));
    step(res(0, 0),              E("full_r0", 0, 0, 0, 0, 1));
    step(idle(),                 E("full_clr", 0, 0, 0, 0, 0));
    step(res(0, 0),              E("full_r1", 0, 0, 0, 0, 0));
    step(res(0, 0),              E("full_r2", 0, 0, 0, 0, 0));
    step(res(0, 0),              E("full_r3", 0, 0, 0, 0, 0));
    step(res(1, 32'h777),        E("full_ignres", 0, 0, 0, 0, 0));
    step(idle(),                 E("full_noflush", 0, 0, 0, 0, 0));

    // Simultaneous push and pop
    begin
      in_t s;
      step(br(32'h900, 0, 0),    E("pp_p0", 0, 0, 0, 0, 0));
      s = br(32'h904, 1, 32'hA00);
      s.rv = 1; s.rt = 0; s.rtgt = 0;
      step(s,                    E("pp_both", 1, 32'hA00, 0, 0, 0));
      step(res(1, 32'hA00),      E("pp_r1", 0, 0, 0, 0, 0));
      step(res(1, 32'hBAD),      E("pp_ignres", 0, 0, 0, 0, 0));
      step(idle(),               E("pp_noflush", 0, 0, 0, 0, 0));
    end

    // Older branch mispredicts while a JALR waits
    step(br(32'h500, 0, 0),      E("jm_br",   0, 0, 0, 0, 0));
    step(jalr(32'h504),          E("jm_jalr", 0, 0, 0, 1, 0));
    step(res(1, 32'h600),        E("jm_res",  0, 0, 0, 1, 0));
    step(idle(),                 E("jm_flush", 1, 32'h600, 1, 0, 0));
    step(res(1, 32'h700),        E("jm_ignres", 0, 0, 0, 0, 0));
    step(idle(),                 E("jm_noflush", 0, 0, 0, 0, 0));

    // Reset while waiting on a JALR with three entries
    step(br(32'h800, 0, 0),      E("rs_p0", 0, 0, 0, 0, 0));
    step(br(32'h804, 0, 0),      E("rs_p1", 0, 0, 0, 0, 0));
    step(jalr(32'h808),          E("rs_jalr", 0, 0, 0, 1, 0));
    step(rst_in(),               NOCHK());
    step(idle(),                 E("rs_post", 0, 0, 0, 0, 0));
    check_perf("rs", 0, 0);
    step(res(1, 32'h111),        E("rs_ignres", 0, 0, 0, 0, 0));
    step(idle(),                 E("rs_noflush", 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
